// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide memory responder: RAM, TX FIFO, RX holding register, halt flag
//
// Optional feature macro: MEM_RESPONDER_RX_EN builds the RX holding register.
// Without it, rx_ready is tied low, rx_data/rx_valid are ignored, and the RX
// fields of the data and status registers read as zero.
//
// Ports:
//   clk_in, rst_in             clock, asynchronous active-low reset
//   mem_a, mem_wr, mem_dout    CPU bus request: address, write strobe, write data
//   mem_din                    registered read data, valid the cycle after the address
//   rdy_out                    CPU ready; low while the TX FIFO is full
//   tx_data, tx_valid, tx_ready  TX FIFO head towards the UART
//   rx_data, rx_valid, rx_ready  incoming UART byte into the holding register
//   sim_halt                   sticky halt request, cleared only by reset
module mem_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

  // Address decode on mem_a[17:0]; bits 31:18 alias.
  logic              sel_ram;
  logic              sel_io;
  logic [2:0]        io_off;
  logic [RAM_AW-1:0] ram_addr;

  assign sel_ram  = (mem_a[17] == 1'b0);
  assign sel_io   = (mem_a[17:16] == 2'b11);
  assign io_off   = mem_a[2:0];
  assign ram_addr = mem_a[RAM_AW-1:0];

  // RAM: no reset so contents survive a reset pulse.
  logic [7:0] ram [2**RAM_AW];

  always_ff @(posedge clk_in) begin
    if (sel_ram && mem_wr) begin
      ram[ram_addr] <= mem_dout;
    end
  end

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          tx_full;
  logic          tx_push;
  logic          tx_pop;

  assign tx_full  = (count == FULL_CNT);
  assign rdy_out  = !tx_full;
  assign tx_valid = (count != '0);
  assign tx_data  = fifo_mem[rd_ptr];
  // Push is judged against the pre-edge count, so a full FIFO rejects the
  // push even when a pop happens at the same edge; the CPU holds the write.
  assign tx_push  = sel_io && mem_wr && (io_off == 3'd0) && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;

  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      fifo_mem[wr_ptr] <= mem_dout;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (tx_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // RX holding register
  logic       rx_full;
  logic [7:0] rx_rd_byte;
  logic       unused_bits;

`ifdef MEM_RESPONDER_RX_EN
  logic [7:0] rx_hold;
  logic       rx_pop;

  // A stalled CPU re-presents its access, so only a read that completes
  // (rdy_out high) may consume the byte.
  assign rx_pop = sel_io && !mem_wr && (io_off == 3'd0) && rx_full && rdy_out;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end else if (rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end
  end

  assign rx_ready    = !rx_full;
  assign rx_rd_byte  = rx_full ? rx_hold : 8'h00;
  assign unused_bits = ^mem_a[31:18];
`else
  assign rx_full     = 1'b0;
  assign rx_ready    = 1'b0;
  assign rx_rd_byte  = 8'h00;
  assign unused_bits = ^{mem_a[31:18], rx_data, rx_valid};
`endif

  // Read data mux
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    if (sel_ram) begin
      rd_data = ram[ram_addr];
    end else if (sel_io) begin
      case (io_off)
        3'd0:    rd_data = rx_rd_byte;
        3'd4:    rd_data = {6'b0, rx_full, tx_full};
        default: rd_data = 8'h00;
      endcase
    end
  end

  // Registered read data and sticky halt
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din  <= 8'h00;
      sim_halt <= 1'b0;
    end else begin
      if (!mem_wr) begin
        mem_din <= rd_data;
      end
      if (sel_io && mem_wr && (io_off == 3'd4)) begin
        sim_halt <= 1'b1;
      end
    end
  end

endmodule
